// File: rtl/md5_pkg.sv
// Shared MD5 definitions: word/block types, init constants, round tables and
// the message-builder state encoding.
package md5_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [15:0][WORD_BITS-1:0] block_t;

  localparam word_t MD5_A0 = 32'h67452301;
  localparam word_t MD5_B0 = 32'hefcdab89;
  localparam word_t MD5_C0 = 32'h98badcfe;
  localparam word_t MD5_D0 = 32'h10325476;

  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

  localparam word_t MD5_T [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amounts repeat every four steps within a round.
  localparam logic [4:0] MD5_S [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] md5_shift(input logic [5:0] step);
    return MD5_S[{step[5:4], step[1:0]}];
  endfunction

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_e;

endpackage

// File: rtl/md5_msg_builder_if.sv
// Key-load and block-output bus of md5_msg_builder.
// MD5_MSG_BUILDER_BIN_TAG_EN adds the binary tag o_tag_bin.
interface md5_msg_builder_if #(
  parameter int unsigned WORD_BITS  = 32,
  parameter int unsigned MAX_DIGITS = 8
);
  logic                      key_valid;
  logic [7:0]                key_byte;
  logic                      key_last;
  logic                      i_enable;
  logic                      i_halt;
  logic                      o_valid;
  logic [16*WORD_BITS-1:0]   o_block;
  logic [4*MAX_DIGITS-1:0]   o_tag;
  logic                      o_key_err;
  logic                      o_overflow;
`ifdef MD5_MSG_BUILDER_BIN_TAG_EN
  logic [31:0]               o_tag_bin;
`endif

  modport slave (
    input  key_valid, key_byte, key_last, i_enable, i_halt,
`ifdef MD5_MSG_BUILDER_BIN_TAG_EN
    output o_tag_bin,
`endif
    output o_valid, o_block, o_tag, o_key_err, o_overflow
  );

  modport master (
    output key_valid, key_byte, key_last, i_enable, i_halt,
`ifdef MD5_MSG_BUILDER_BIN_TAG_EN
    input  o_tag_bin,
`endif
    input  o_valid, o_block, o_tag, o_key_err, o_overflow
  );
endinterface

// File: rtl/md5_msg_builder_bcd_counter.sv
// Decimal candidate counter: BCD digits, significant-digit count and all-9s
// flag. Resets to 1.
module bcd_counter #(
  parameter int unsigned MAX_DIGITS = 8,
  localparam int unsigned NW = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_i,
  output logic [4*MAX_DIGITS-1:0] digits_o,
  output logic [NW-1:0]           ndigits_o,
  output logic                    all_nines_o
);
  logic [MAX_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [NW-1:0]              nd_q, nd_d;
  logic                       carry;

  always_comb begin
    dig_d = dig_q;
    carry = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    // The value is never zero, so the highest nonzero digit sets the length.
    nd_d = NW'(1);
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (dig_d[i] != 4'd0) nd_d = NW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q    <= '0;
      dig_q[0] <= 4'd1;
      nd_q     <= NW'(1);
    end else if (inc_i) begin
      dig_q <= dig_d;
      nd_q  <= nd_d;
    end
  end

  always_comb begin
    all_nines_o = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (dig_q[i] != 4'd9) all_nines_o = 1'b0;
    end
  end

  assign digits_o  = dig_q;
  assign ndigits_o = nd_q;

endmodule

// File: rtl/md5_msg_builder.sv
// Builds one padded MD5 block per enabled cycle for key || decimal(N).
// MD5_MSG_BUILDER_BIN_TAG_EN adds a parallel binary tag output.
module md5_msg_builder #(
  parameter int unsigned WORD_BITS     = 32,
  parameter int unsigned MAX_KEY_BYTES = 16,
  parameter int unsigned MAX_DIGITS    = 8
) (
  input logic               clk,
  input logic               reset,
  md5_msg_builder_if.slave  bus
);
  import md5_pkg::*;

  localparam int unsigned KLW = $clog2(MAX_KEY_BYTES + 1);
  localparam int unsigned KIW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
  localparam int unsigned DIW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int unsigned NW  = $clog2(MAX_DIGITS + 1);

  if (WORD_BITS != 32) begin : g_word_chk
    $error("md5_msg_builder: WORD_BITS must be 32");
  end
  if (MAX_KEY_BYTES + MAX_DIGITS + 9 > 64) begin : g_len_chk
    $error("md5_msg_builder: key plus digits does not fit a single block");
  end

  state_e                        state_q;
  logic [MAX_KEY_BYTES-1:0][7:0] key_q;
  logic [KLW-1:0]                key_len_q;
  logic                          key_err_q, overflow_q, valid_q;
  block_t                        block_q, block_d;
  logic [4*MAX_DIGITS-1:0]       tag_q;

  logic [4*MAX_DIGITS-1:0]       digits;
  logic [MAX_DIGITS-1:0][3:0]    dig;
  logic [NW-1:0]                 ndigits;
  logic                          all_nines;
  logic                          emit, cnt_inc;

  assign emit    = (state_q == RUN) && !bus.i_halt && bus.i_enable;
  assign cnt_inc = emit && !all_nines;
  assign dig     = digits;

  bcd_counter #(.MAX_DIGITS(MAX_DIGITS)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (cnt_inc),
    .digits_o    (digits),
    .ndigits_o   (ndigits),
    .all_nines_o (all_nines)
  );

  // Byte b of the message lands at block bits [8b+7:8b].
  logic [63:0][7:0] msg_bytes;
  int unsigned      klen, nd, mlen, bitlen;

  always_comb begin
    msg_bytes = '0;
    klen   = 32'(key_len_q);
    nd     = 32'(ndigits);
    mlen   = klen + nd;
    bitlen = mlen * 8;
    for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
      if (b < klen) msg_bytes[b] = key_q[b];
    end
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      if (d < nd) msg_bytes[6'(klen + d)] = {4'h3, dig[DIW'(nd - 1 - d)]};
    end
    msg_bytes[6'(mlen)] = MD5_PAD_BYTE;
    msg_bytes[56]       = bitlen[7:0];
    msg_bytes[57]       = bitlen[15:8];
    block_d = msg_bytes;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      key_q      <= '0;
      key_len_q  <= '0;
      key_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      block_q    <= '0;
      tag_q      <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          valid_q <= 1'b0;
          if (bus.key_valid) begin
            if (key_len_q < KLW'(MAX_KEY_BYTES)) begin
              key_q[key_len_q[KIW-1:0]] <= bus.key_byte;
              key_len_q                 <= key_len_q + KLW'(1);
            end else begin
              key_err_q <= 1'b1;
            end
            if (bus.key_last) state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.i_halt) begin
            valid_q <= 1'b0;
            state_q <= HALT;
          end else if (bus.i_enable) begin
            valid_q <= 1'b1;
            block_q <= block_d;
            tag_q   <= digits;
            if (all_nines) begin
              overflow_q <= 1'b1;
              state_q    <= HALT;
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        HALT:    valid_q <= 1'b0;
        default: state_q <= LOAD;
      endcase
    end
  end

`ifdef MD5_MSG_BUILDER_BIN_TAG_EN
  logic [31:0] bin_q, tag_bin_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q     <= 32'd1;
      tag_bin_q <= '0;
    end else if (emit) begin
      tag_bin_q <= bin_q;
      if (cnt_inc) bin_q <= bin_q + 32'd1;
    end
  end

  assign bus.o_tag_bin = tag_bin_q;
`endif

  assign bus.o_valid    = valid_q;
  assign bus.o_block    = block_q;
  assign bus.o_tag      = tag_q;
  assign bus.o_key_err  = key_err_q;
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_md5_msg_builder.sv
// Directed bench: a default instance and a MAX_DIGITS=2 instance share stimulus.
module tb_md5_msg_builder;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid, key_last, i_enable, i_halt;
  logic [7:0] key_byte;

  int checks   = 0;
  int failures = 0;
  int va_cnt   = 0;
  int vb_cnt   = 0;

  always #5 clk = ~clk;

  md5_msg_builder_if #(.WORD_BITS(32), .MAX_DIGITS(8)) bus_a ();
  md5_msg_builder_if #(.WORD_BITS(32), .MAX_DIGITS(2)) bus_b ();

  assign bus_a.key_valid = key_valid;
  assign bus_a.key_byte  = key_byte;
  assign bus_a.key_last  = key_last;
  assign bus_a.i_enable  = i_enable;
  assign bus_a.i_halt    = i_halt;
  assign bus_b.key_valid = key_valid;
  assign bus_b.key_byte  = key_byte;
  assign bus_b.key_last  = key_last;
  assign bus_b.i_enable  = i_enable;
  assign bus_b.i_halt    = i_halt;

  md5_msg_builder #(.WORD_BITS(32), .MAX_KEY_BYTES(16), .MAX_DIGITS(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  md5_msg_builder #(.WORD_BITS(32), .MAX_KEY_BYTES(16), .MAX_DIGITS(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always @(negedge clk) begin
    if (bus_a.o_valid) va_cnt++;
    if (bus_b.o_valid) vb_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] blk(input logic [31:0] m0, m1, m2, m3, m4, m14);
    logic [511:0] r;
    r = '0;
    r[31:0]    = m0;
    r[63:32]   = m1;
    r[95:64]   = m2;
    r[127:96]  = m3;
    r[159:128] = m4;
    r[479:448] = m14;
    return r;
  endfunction

  task automatic load_key(input string s);
    for (int i = 0; i < s.len(); i++) begin
      key_valid = 1'b1;
      key_byte  = s[i];
      key_last  = (i == s.len() - 1);
      tick();
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_last = 1'b0; key_byte = 8'h00;
    i_enable = 1'b0; i_halt = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus_a.o_valid, 0);
    chk("rst_block", bus_a.o_block, 0);
    chk("rst_tag", bus_a.o_tag, 0);
    chk("rst_keyerr", bus_a.o_key_err, 0);
    chk("rst_ovf_b", bus_b.o_overflow, 0);
    reset = 1'b0;

    // Enable/halt during LOAD have no effect.
    i_enable = 1'b1;
    tick();
    chk("load_ignores_en", bus_a.o_valid, 0);
    i_enable = 1'b0;

    load_key("abcdef");
    i_enable = 1'b1;
    tick();
    chk("n1_valid", bus_a.o_valid, 1);
    chk("n1_block", bus_a.o_block, blk(32'h64636261, 32'h80316665, 0, 0, 0, 32'h38));
    chk("n1_tag", bus_a.o_tag, 32'h1);
    i_enable = 1'b0;
    tick();
    chk("gap1_valid", bus_a.o_valid, 0);
    chk("gap1_block", bus_a.o_block, blk(32'h64636261, 32'h80316665, 0, 0, 0, 32'h38));
    chk("gap1_tag", bus_a.o_tag, 32'h1);
    tick();
    chk("gap2_valid", bus_a.o_valid, 0);
    chk("gap2_tag", bus_a.o_tag, 32'h1);
    i_enable = 1'b1;
    tick();
    chk("n2_valid", bus_a.o_valid, 1);
    chk("n2_tag", bus_a.o_tag, 32'h2);
    chk("n2_block", bus_a.o_block, blk(32'h64636261, 32'h80326665, 0, 0, 0, 32'h38));
    i_enable = 1'b0;
    tick();
    chk("pulse_count_2", va_cnt, 2);

    i_enable = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("n10_tag", bus_a.o_tag, 32'h10);
    chk("n10_block", bus_a.o_block, blk(32'h64636261, 32'h30316665, 32'h80, 0, 0, 32'h40));
    chk("n10_tag_b", bus_b.o_tag, 32'h10);

    for (int i = 0; i < 89; i++) tick();
    chk("n99_valid_b", bus_b.o_valid, 1);
    chk("n99_tag_b", bus_b.o_tag, 32'h99);
    chk("n99_block_b", bus_b.o_block, blk(32'h64636261, 32'h39396665, 32'h80, 0, 0, 32'h40));
    chk("n99_tag_a", bus_a.o_tag, 32'h99);
    tick();
    chk("ovf_b", bus_b.o_overflow, 1);
    chk("ovf_valid_b", bus_b.o_valid, 0);
    chk("n100_tag_a", bus_a.o_tag, 32'h100);
    chk("n100_block_a", bus_a.o_block, blk(32'h64636261, 32'h30316665, 32'h00008030, 0, 0, 32'h48));
    chk("no_ovf_a", bus_a.o_overflow, 0);
`ifdef MD5_MSG_BUILDER_BIN_TAG_EN
    chk("n100_bin_a", bus_a.o_tag_bin, 100);
`endif
    for (int i = 0; i < 3; i++) tick();
    chk("ovf_hold_valid_b", bus_b.o_valid, 0);
    chk("ovf_hold_tag_b", bus_b.o_tag, 32'h99);
    chk("pulse_count_b", vb_cnt, 99);

    // Reset while running with enable still high.
    reset = 1'b1;
    tick();
    chk("midrun_rst_valid", bus_a.o_valid, 0);
    chk("midrun_rst_block", bus_a.o_block, 0);
    chk("midrun_rst_tag", bus_a.o_tag, 0);
    chk("midrun_rst_ovf_b", bus_b.o_overflow, 0);
    reset = 1'b0;
    i_enable = 1'b0;

    load_key("abcdef");
    i_halt = 1'b1;
    i_enable = 1'b1;
    tick();
    chk("halt_wins_valid", bus_a.o_valid, 0);
    i_halt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("halted_valid", bus_a.o_valid, 0);
    chk("halted_tag", bus_a.o_tag, 0);
    i_enable = 1'b0;
    do_reset();
    load_key("abcdef");
    i_enable = 1'b1;
    tick();
    chk("reload_valid", bus_a.o_valid, 1);
    chk("reload_tag", bus_a.o_tag, 32'h1);
    chk("reload_block", bus_a.o_block, blk(32'h64636261, 32'h80316665, 0, 0, 0, 32'h38));
    i_enable = 1'b0;

    do_reset();
    load_key("abcdefghijklmnopq");
    chk("keyerr", bus_a.o_key_err, 1);
    chk("keyerr_b", bus_b.o_key_err, 1);
    i_enable = 1'b1;
    tick();
    chk("keyerr_block", bus_a.o_block,
        blk(32'h64636261, 32'h68676665, 32'h6c6b6a69, 32'h706f6e6d, 32'h00008031, 32'h88));
    chk("keyerr_tag", bus_a.o_tag, 32'h1);
    i_enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md5_msg_builder.md
Name: md5_msg_builder

Overview:
- Upstream feeder for the unrolled MD5 step pipeline in the AoC 2015 day 4 solver.
- Loads the secret key once. Then, every enabled cycle, emits one padded 512-bit MD5 message block for key || decimal(N), with N = 1, 2, 3, ….
- Outputs feed the per-step message inputs and the valid chain of the first step; the candidate number travels as a tag so the downstream checker can report it.

Parameters:
- WORD_BITS, 32, MD5 word width; fixed at 32, other values unsupported.
- MAX_KEY_BYTES, 16, capacity of the key buffer in bytes.
- MAX_DIGITS, 8, number of BCD digits in the candidate counter.
- Legality: MAX_KEY_BYTES + MAX_DIGITS + 9 <= 64, so a block is always a single 512-bit block. Elaboration-time assertion.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  key byte strobe
- key_byte  in  8  ASCII key byte, first character first
- key_last  in  1  marks the final key byte (qualified by key_valid)
- i_enable  in  1  pipeline advance permission; no block is produced while low
- i_halt  in  1  downstream found a match; stop generating
- o_valid  out  1  block valid, one-cycle strobe per block
- o_block  out  16*WORD_BITS  message words M[0..15]; M[k] at bits [32k+31:32k]; bytes little-endian within each word
- o_tag  out  4*MAX_DIGITS  BCD value of N for this block
- o_key_err  out  1  sticky; key exceeded MAX_KEY_BYTES
- o_overflow  out  1  sticky; counter passed all-9s

Behaviour:
- Reset values:
  - o_valid=0, o_key_err=0, o_overflow=0, o_tag=0, o_block=0.
  - Key length 0; counter N=1, digit count 1; state LOAD.
  - Reset in any state aborts immediately and returns to LOAD; no partial block is emitted.
- State LOAD:
  - Each key_valid stores key_byte at index key_len, then key_len++.
  - Bytes beyond MAX_KEY_BYTES are dropped and set o_key_err; length saturates.
  - key_valid & key_last moves to RUN at the next edge. The key_last byte itself is stored.
  - i_enable and i_halt are ignored in LOAD.
- State RUN, per cycle:
  - If i_halt=1: go to HALT; o_valid=0 next cycle. i_halt wins over i_enable when both are high.
  - Else if i_enable=1: register the block for current N, set o_valid=1 and o_tag=N next cycle, and increment N in BCD on the same edge. Latency is 1 cycle from enable to o_valid.
  - Else: o_valid=0; N holds. o_block/o_tag hold their last values.
- Block format, L = key_len + ndigits bytes:
  - Bytes 0..key_len-1: key.
  - Next ndigits bytes: ASCII digits of N, most significant first, no leading zeros.
  - Byte L: 0x80.
  - Bytes L+1..55: 0x00.
  - Bytes 56..63: 64-bit little-endian bit length 8*L, so M[14]=8*L and M[15]=0.
- Counter rules:
  - ndigits increments when a carry leaves the top significant digit (9→10, 99→100, …).
  - Incrementing all-9s at MAX_DIGITS sets o_overflow and moves to HALT. The all-9s block itself is still emitted.
- State HALT: terminal. o_valid=0; exit only via reset.
- Handshake: there is no backpressure from the MD5 pipeline. i_enable is the only flow control, and i_halt may arrive any number of cycles after the matching block.

Optional Feature:
- Macro MD5_MSG_BUILDER_BIN_TAG_EN.
- Defined: adds output o_tag_bin (32 bits), the binary value of N registered alongside o_tag. It is maintained as a parallel binary counter (reset 1), so no BCD-to-binary conversion is needed.
- Undefined: port absent; only BCD o_tag exists.

Decomposition:
- Shared package md5_pkg:
  - WORD_BITS, word_t, block_t (16 x word_t).
  - MD5 init constants A0/B0/C0/D0, per-round T and shift tables.
  - Padding byte constant 0x80.
  - State enum {LOAD, RUN, HALT}.
- One sub-module, bcd_counter:
  - MAX_DIGITS BCD digits with increment enable.
  - Outputs: digits, significant-digit count, all-nines flag.
  - Synchronous reset to value 1.

Test Plan:
- Key "abcdef", key_last on 'f', enable 1 cycle → M[0]=0x64636261, M[1]=0x80316665, M[2..13]=0, M[14]=0x38, M[15]=0, o_tag=0x00000001.
- Same key, 9 enables then 1 more → 10th block M[1]=0x30316665, M[2]=0x00000080, M[14]=0x40, o_tag=0x00000010.
- Enable toggled 1,0,0,1 → exactly two o_valid pulses with tags 1 then 2; o_block and o_tag stable while enable is low.
- i_halt and i_enable both high in RUN → no further o_valid; state HALT until reset; after reset, reload the key and the first tag is 1 again.
- 17 key bytes with MAX_KEY_BYTES=16 → o_key_err=1; block uses the first 16 bytes only.
- MAX_DIGITS=2, run to 99 → block with tag 0x99 emitted, then o_overflow=1, no further o_valid; reset mid-RUN clears all outputs next cycle.
